dp_ram_block_mover: RTL and testbench

- Initiator that drives both ports of the team's dual-port RAM to perform block copy and block fill, one word per clock.
- Port 0 is used only for reads and port 1 only for writes.
- Sits between a control FSM/CPU-side register block and the RAM instance.
- Used for frame buffer moves and memory initialisation.

---
 rtl/dp_ram_block_mover_if.sv | 18 +
 rtl/dp_ram_block_mover.sv | 108 ++++++++++
 tb/tb_dp_ram_block_mover.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dp_ram_block_mover_if.sv
// dp_ram_block_mover_if: command and dual-port RAM signals of the block mover
interface dp_ram_block_mover_if #(
  parameter int add_wd = 4,
  parameter int data_wd = 32
);
  logic start, mode, abort, busy, done, cs, rd0, wr1, rd1, wr0;
  logic [add_wd-1:0] src_add, dst_add, rd_add0, wr_add1, rd_add1, wr_add0;
  logic [add_wd:0] len;
  logic [data_wd-1:0] fill_data, rd_data0, wr_data1, wr_data0;
  modport master (
    input start, mode, src_add, dst_add, len, fill_data, abort, rd_data0,
    output busy, done, cs, rd0, rd_add0, wr1, wr_add1, wr_data1, rd1, wr0, rd_add1, wr_add0, wr_data0
  );
  modport slave (
    output start, mode, src_add, dst_add, len, fill_data, abort, rd_data0,
    input busy, done, cs, rd0, rd_add0, wr1, wr_add1, wr_data1, rd1, wr0, rd_add1, wr_add0, wr_data0
  );
endinterface

// File: rtl/dp_ram_block_mover.sv
// dp_ram_block_mover: block copy/fill engine reading RAM port 0 and writing port 1
module dp_ram_block_mover #(
  parameter int add_wd = 4,
  parameter int data_wd = 32
) (
  input logic clk,
  input logic rst,
  dp_ram_block_mover_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t st_q;
  logic mode_q, desc_q, pend_q, busy_q, done_q, rd0_q, wr1_q;
  logic [add_wd:0] len_q, cnt_q;
  logic [add_wd-1:0] rd_add0_q, wr_add1_q, dptr_q, span, step;
  logic [data_wd-1:0] wr_data1_q;
  logic desc, last;
  assign desc = !bus.mode && bus.dst_add > bus.src_add;
  assign span = bus.len[add_wd-1:0] - add_wd'(1);
  assign step = desc_q ? '1 : add_wd'(1);
  assign last = bus.abort || cnt_q == len_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.rd0 = rd0_q;
  assign bus.rd_add0 = rd_add0_q;
  assign bus.wr1 = wr1_q;
  assign bus.wr_add1 = wr_add1_q;
  assign bus.wr_data1 = wr_data1_q;
  assign bus.cs = rd0_q | wr1_q;
  assign bus.rd1 = 1'b0;
  assign bus.wr0 = 1'b0;
  assign bus.rd_add1 = '0;
  assign bus.wr_add0 = '0;
  assign bus.wr_data0 = '0;
  // command FSM; copy reads flow through pend_q (data arriving) into the registered write port
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      mode_q <= 1'b0;
      desc_q <= 1'b0;
      pend_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rd0_q <= 1'b0;
      wr1_q <= 1'b0;
      len_q <= '0;
      cnt_q <= '0;
      rd_add0_q <= '0;
      wr_add1_q <= '0;
      dptr_q <= '0;
      wr_data1_q <= '0;
    end else begin
      if (st_q == DRAIN || (st_q == RUN && !mode_q)) begin
        pend_q <= rd0_q;
        wr1_q <= pend_q;
        if (pend_q) begin
          wr_add1_q <= dptr_q;
          wr_data1_q <= bus.rd_data0;
          dptr_q <= dptr_q + step;
        end
      end
      case (st_q)
        IDLE: if (bus.start) begin
          mode_q <= bus.mode;
          desc_q <= desc;
          len_q <= bus.len;
          cnt_q <= (add_wd+1)'(1);
          if (bus.len == '0) begin
            done_q <= 1'b1;
            st_q <= DONE;
          end else begin
            busy_q <= 1'b1;
            st_q <= RUN;
            rd0_q <= !bus.mode;
            rd_add0_q <= desc ? bus.src_add + span : bus.src_add;
            dptr_q <= desc ? bus.dst_add + span : bus.dst_add;
            wr1_q <= bus.mode;
            wr_add1_q <= bus.dst_add;
            wr_data1_q <= bus.fill_data;
          end
        end
        RUN: if (last) begin
          rd0_q <= 1'b0;
          if (mode_q) begin
            wr1_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            st_q <= DONE;
          end else begin
            st_q <= DRAIN;
          end
        end else begin
          cnt_q <= cnt_q + (add_wd+1)'(1);
          if (mode_q) wr_add1_q <= wr_add1_q + add_wd'(1);
          else rd_add0_q <= rd_add0_q + step;
        end
        DRAIN: if (!pend_q) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          st_q <= DONE;
        end
        default: begin
          done_q <= 1'b0;
          st_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dp_ram_block_mover.sv
// tb_dp_ram_block_mover: directed and randomized checks of the block mover against a RAM model
module tb_dp_ram_block_mover;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NC = 22;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic pl = 1'b0;
  logic [DW-1:0] mem [16];
  logic [DW-1:0] snap [16];
  logic [DW-1:0] pl_data [16];
  logic [DW-1:0] e_mem [16];
  logic [31:0] o_rd, o_wr, o_busy, o_done, o_cs, o_tie;
  logic [31:0] e_rd, e_wr, e_busy, e_done;
  logic [AW-1:0] o_ra [NC];
  logic [AW-1:0] o_wa [NC];
  logic [DW-1:0] o_wd [NC];
  logic [AW-1:0] e_ra [NC];
  logic [AW-1:0] e_wa [NC];
  logic [DW-1:0] e_wd [NC];

  always #5 clk = ~clk;

  dp_ram_block_mover_if #(.add_wd(AW), .data_wd(DW)) bus ();
  dp_ram_block_mover #(.add_wd(AW), .data_wd(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // synchronous dual-port RAM: read data valid the cycle after the read strobe
  always @(posedge clk) begin
    if (pl) for (int i = 0; i < 16; i++) mem[i] <= pl_data[i];
    else if (bus.wr1) mem[bus.wr_add1] <= bus.wr_data1;
    if (bus.rd0) bus.rd_data0 <= mem[bus.rd_add0];
  end

  function automatic logic [86:0] outs();
    return {bus.busy, bus.done, bus.cs, bus.rd0, bus.rd_add0, bus.wr1, bus.wr_add1, bus.wr_data1,
            bus.rd1, bus.wr0, bus.rd_add1, bus.wr_add0, bus.wr_data0};
  endfunction

  task automatic load();
    for (int i = 0; i < 16; i++) pl_data[i] = $urandom;
    pl = 1'b1;
    @(posedge clk); #1;
    pl = 1'b0;
  endtask

  task automatic run_cmd(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [AW:0] l, input logic [DW-1:0] f, input int ab, input int rs);
    for (int i = 0; i < 16; i++) snap[i] = mem[i];
    {o_rd, o_wr, o_busy, o_done, o_cs, o_tie} = '0;
    bus.start = 1'b1; bus.mode = m; bus.src_add = s; bus.dst_add = d; bus.len = l; bus.fill_data = f;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mode = ~m;
    bus.src_add = AW'($urandom); bus.dst_add = AW'($urandom);
    bus.len = (AW+1)'($urandom_range(1, 16)); bus.fill_data = $urandom;
    for (int c = 1; c < NC; c++) begin
      bus.abort = (c == ab);
      bus.start = (c == rs);
      @(negedge clk);
      o_rd[c] = bus.rd0; o_ra[c] = bus.rd_add0;
      o_wr[c] = bus.wr1; o_wa[c] = bus.wr_add1; o_wd[c] = bus.wr_data1;
      o_busy[c] = bus.busy; o_done[c] = bus.done; o_cs[c] = bus.cs;
      o_tie[c] = |{bus.rd1, bus.wr0, bus.rd_add1, bus.wr_add0, bus.wr_data0};
      @(posedge clk); #1;
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;
  endtask

  // element k of a block of l words: ascending base+k, descending base+l-1-k, mod 16
  task automatic model(input logic m, input int s, input int d, input int l, input logic [DW-1:0] f, input int ab);
    int n, lastc, a, w;
    bit dsc;
    n = (ab >= 1 && ab < l) ? ab : l;
    dsc = !m && d > s;
    {e_rd, e_wr, e_busy, e_done} = '0;
    for (int i = 0; i < 16; i++) e_mem[i] = snap[i];
    for (int k = 0; k < n; k++) begin
      a = (dsc ? s + l - 1 - k : s + k) & 15;
      w = (dsc ? d + l - 1 - k : d + k) & 15;
      if (!m) begin
        e_rd[1+k] = 1'b1; e_ra[1+k] = AW'(a);
        e_wr[3+k] = 1'b1; e_wa[3+k] = AW'(w); e_wd[3+k] = snap[a];
      end else begin
        e_wr[1+k] = 1'b1; e_wa[1+k] = AW'(w); e_wd[1+k] = f;
      end
      e_mem[w] = m ? f : snap[a];
    end
    lastc = (l == 0) ? 0 : (m ? n : n + 2);
    for (int c = 1; c <= lastc; c++) e_busy[c] = 1'b1;
    e_done[lastc+1] = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (outs() !== '0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", outs()); end
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_copy_ascending();
    load();
    run_cmd(1'b0, 4'd0, 4'd8, 5'd4, 32'h0, 0, 0);
    checks++; if (o_rd !== 32'h1E) begin failures++; $display("FAIL asc_rd_cycles got=%h exp=1e", o_rd); end
    checks++; if (o_wr !== 32'h78) begin failures++; $display("FAIL asc_wr_cycles got=%h exp=78", o_wr); end
    checks++; if (o_busy !== 32'h7E) begin failures++; $display("FAIL asc_busy_cycles got=%h exp=7e", o_busy); end
    checks++; if (o_done !== 32'h80) begin failures++; $display("FAIL asc_done_cycle got=%h exp=80", o_done); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[8+i] !== pl_data[i]) begin failures++; $display("FAIL asc_mem%0d got=%h exp=%h", 8+i, mem[8+i], pl_data[i]); end
    end
  endtask

  task automatic test_overlap_descending();
    load();
    run_cmd(1'b0, 4'd2, 4'd4, 5'd4, 32'h0, 0, 0);
    checks++; if (o_ra[1] !== 4'd5) begin failures++; $display("FAIL desc_first_rd got=%0d exp=5", o_ra[1]); end
    checks++; if (o_wa[3] !== 4'd7) begin failures++; $display("FAIL desc_first_wr got=%0d exp=7", o_wa[3]); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[4+i] !== pl_data[2+i]) begin failures++; $display("FAIL desc_mem%0d got=%h exp=%h", 4+i, mem[4+i], pl_data[2+i]); end
    end
  endtask

  task automatic test_fill_wrap();
    logic [AW-1:0] xa [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
    load();
    run_cmd(1'b1, 4'd3, 4'd14, 5'd4, 32'hDEADBEEF, 0, 0);
    checks++; if (o_rd !== 32'h0) begin failures++; $display("FAIL fill_rd got=%h exp=0", o_rd); end
    checks++; if (o_wr !== 32'h1E) begin failures++; $display("FAIL fill_wr_cycles got=%h exp=1e", o_wr); end
    checks++; if (o_done !== 32'h20) begin failures++; $display("FAIL fill_done_cycle got=%h exp=20", o_done); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_wa[1+i] !== xa[i]) begin failures++; $display("FAIL fill_addr%0d got=%0d exp=%0d", i, o_wa[1+i], xa[i]); end
      checks++;
      if (mem[xa[i]] !== 32'hDEADBEEF) begin failures++; $display("FAIL fill_mem%0d got=%h exp=deadbeef", xa[i], mem[xa[i]]); end
    end
    checks++; if (mem[2] !== pl_data[2]) begin failures++; $display("FAIL fill_untouched got=%h exp=%h", mem[2], pl_data[2]); end
  endtask

  task automatic test_len_zero();
    run_cmd(1'b0, 4'd3, 4'd5, 5'd0, 32'h0, 0, 0);
    checks++; if (o_done !== 32'h2) begin failures++; $display("FAIL len0_done got=%h exp=2", o_done); end
    checks++; if (o_cs !== 32'h0) begin failures++; $display("FAIL len0_cs got=%h exp=0", o_cs); end
    checks++; if (o_busy !== 32'h0) begin failures++; $display("FAIL len0_busy got=%h exp=0", o_busy); end
  endtask

  task automatic test_abort();
    load();
    run_cmd(1'b0, 4'd6, 4'd0, 5'd10, 32'h0, 3, 0);
    checks++; if (o_rd !== 32'hE) begin failures++; $display("FAIL abort_rd got=%h exp=e", o_rd); end
    checks++; if (o_wr !== 32'h38) begin failures++; $display("FAIL abort_wr got=%h exp=38", o_wr); end
    checks++; if (o_done !== 32'h40) begin failures++; $display("FAIL abort_done got=%h exp=40", o_done); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[i] !== pl_data[i < 3 ? 6 + i : i]) begin
        failures++; $display("FAIL abort_mem%0d got=%h exp=%h", i, mem[i], pl_data[i < 3 ? 6 + i : i]);
      end
    end
  endtask

  task automatic test_busy_start();
    load();
    run_cmd(1'b0, 4'd0, 4'd8, 5'd4, 32'h0, 0, 2);
    checks++; if (o_rd !== 32'h1E) begin failures++; $display("FAIL busy_start_rd got=%h exp=1e", o_rd); end
    checks++; if (o_wr !== 32'h78) begin failures++; $display("FAIL busy_start_wr got=%h exp=78", o_wr); end
    checks++; if (o_done !== 32'h80) begin failures++; $display("FAIL busy_start_done got=%h exp=80", o_done); end
    run_cmd(1'b0, 4'd0, 4'd8, 5'd4, 32'h0, 0, 7);
    checks++; if (o_cs !== 32'h7E) begin failures++; $display("FAIL done_start_cs got=%h exp=7e", o_cs); end
    checks++; if (o_done !== 32'h80) begin failures++; $display("FAIL done_start_done got=%h exp=80", o_done); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[i] !== pl_data[(i >= 8 && i < 12) ? i - 8 : i]) begin
        failures++; $display("FAIL busy_start_mem%0d got=%h exp=%h", i, mem[i], pl_data[(i >= 8 && i < 12) ? i - 8 : i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    load();
    bus.start = 1'b1; bus.mode = 1'b0; bus.src_add = 4'd0; bus.dst_add = 4'd8; bus.len = 5'd8;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (outs() !== '0) begin failures++; $display("FAIL reset_mid_outputs%0d got=%h exp=0", i, outs()); end
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (outs() !== '0) begin failures++; $display("FAIL reset_mid_quiet%0d got=%h exp=0", i, outs()); end
    end
    @(posedge clk); #1;
    run_cmd(1'b1, 4'd0, 4'd0, 5'd3, 32'h12345678, 0, 0);
    checks++; if (o_wr !== 32'hE) begin failures++; $display("FAIL reset_mid_restart_wr got=%h exp=e", o_wr); end
    checks++; if (o_done !== 32'h10) begin failures++; $display("FAIL reset_mid_restart_done got=%h exp=10", o_done); end
  endtask

  task automatic test_random();
    logic m;
    int l, s, d, ab, rs, n, lastc;
    logic [DW-1:0] f;
    logic [DW+2*AW+5:0] ov, ev;
    load();
    for (int t = 0; t < 40; t++) begin
      m = 1'($urandom_range(0, 1));
      l = $urandom_range(0, 16);
      s = m ? $urandom_range(0, 15) : $urandom_range(0, 16 - l);
      d = m ? $urandom_range(0, 15) : $urandom_range(0, 16 - l);
      f = $urandom;
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, l + 1) : 0;
      n = (ab >= 1 && ab < l) ? ab : l;
      lastc = (l == 0) ? 0 : (m ? n : n + 2);
      rs = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lastc + 1) : 0;
      run_cmd(m, AW'(s), AW'(d), (AW+1)'(l), f, ab, rs);
      model(m, s, d, l, f, ab);
      for (int c = 1; c < NC; c++) begin
        ov = {o_rd[c], e_rd[c] ? o_ra[c] : 4'h0, o_wr[c], e_wr[c] ? o_wa[c] : 4'h0, e_wr[c] ? o_wd[c] : 32'h0,
              o_busy[c], o_done[c], o_cs[c], o_tie[c]};
        ev = {e_rd[c], e_rd[c] ? e_ra[c] : 4'h0, e_wr[c], e_wr[c] ? e_wa[c] : 4'h0, e_wr[c] ? e_wd[c] : 32'h0,
              e_busy[c], e_done[c], e_rd[c] | e_wr[c], 1'b0};
        checks++;
        if (ov !== ev) begin failures++; $display("FAIL random_cmd%0d cycle%0d got=%h exp=%h", t, c, ov, ev); end
      end
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (mem[i] !== e_mem[i]) begin failures++; $display("FAIL random_cmd%0d mem%0d got=%h exp=%h", t, i, mem[i], e_mem[i]); end
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.mode = 1'b0; bus.src_add = '0; bus.dst_add = '0;
    bus.len = '0; bus.fill_data = '0; bus.abort = 1'b0;
    test_reset();
    test_copy_ascending();
    test_overlap_descending();
    test_fill_wrap();
    test_len_zero();
    test_abort();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
